// File: rtl/mul_div_unit_pkg.sv
// ============================================================================
// Module  : md_defs (package)
// Purpose : Shared encodings for the iterative multiply/divide unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package md_defs;

  // Operation encodings as decoded from the instruction
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Control state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // LO value reported for a zero divisor
  localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_div_unit_if.sv
// ============================================================================
// Module  : mul_div_unit_if
// Purpose : Request/result bundle between the EX stage and the mul/div unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] MDIn1;
  logic [WIDTH-1:0] MDIn2;
  logic             Flush;
  logic             HiWrite;
  logic             LoWrite;
  logic [WIDTH-1:0] WrData;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  // Pipeline side: issues requests, observes status and HI/LO
  modport master (
    output Start, Op, MDIn1, MDIn2, Flush, HiWrite, LoWrite, WrData,
    input  Busy, Done, DivByZero, Hi, Lo
  );

  // Unit side
  modport slave (
    input  Start, Op, MDIn1, MDIn2, Flush, HiWrite, LoWrite, WrData,
    output Busy, Done, DivByZero, Hi, Lo
  );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit_step.sv
// ============================================================================
// Module  : md_step
// Purpose : One radix-2 iteration: shift-add multiply or restoring divide.
//           Multiply: {hi,lo} holds partial product with multiplier in lo.
//           Divide  : hi holds partial remainder, lo shifts dividend out and
//                     quotient bits in.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module md_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Single iteration; a borrow in diff[WIDTH] means the divisor did not fit
  always_comb begin
    sum     = {1'b0, acc_hi} + {1'b0, opnd};
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    nxt_hi  = acc_hi;
    nxt_lo  = acc_lo;
    if (is_div) begin
      if (!diff[WIDTH]) begin
        nxt_hi = diff[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else if (acc_lo[0]) begin
      {nxt_hi, nxt_lo} = {sum, acc_lo[WIDTH-1:1]};
    end else begin
      {nxt_hi, nxt_lo} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module  : mul_div_unit
// Purpose : Iterative mult/multu/div/divu unit owning the HI/LO registers.
//           IDLE -> CALC (WIDTH steps) -> FIX (sign correction, HI/LO write).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit
  import md_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         Clk,
  input logic         Reset,
  mul_div_unit_if.slave md
);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               launch, last_step, busy;
  logic               n1, n2, zero_div;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .acc_hi (acc_hi_q),
    .acc_lo (acc_lo_q),
    .opnd   (opnd_q),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  assign launch    = (state_q == S_IDLE) && md.Start && !md.Flush;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Operand magnitudes/signs at launch, and sign-corrected results in FIX
  always_comb begin
    n1       = op_is_signed(md.Op) && md.MDIn1[WIDTH-1];
    n2       = op_is_signed(md.Op) && md.MDIn2[WIDTH-1];
    mag1     = n1 ? -md.MDIn1 : md.MDIn1;
    mag2     = n2 ? -md.MDIn2 : md.MDIn2;
    zero_div = op_is_div(md.Op) && (md.MDIn2 == '0);
    prod     = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    quo      = neg_q ? -acc_lo_q : acc_lo_q;
    rem      = rem_neg_q ? -acc_hi_q : acc_hi_q;
  end

  // Control state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; Flush squashes any in-flight operation
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_CALC;
      S_CALC:  if (md.Flush) state_d = S_IDLE;
               else if (last_step) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Datapath next values: latch on launch, iterate in CALC, retire in FIX
  always_comb begin
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md.HiWrite) hi_d = md.WrData;
        if (md.LoWrite) lo_d = md.WrData;
        if (launch) begin
          is_div_d = op_is_div(md.Op);
          cnt_d    = '0;
          acc_hi_d = '0;
          opnd_d   = mag2;
          dz_d     = zero_div;
          dbz_d    = 1'b0;
          // A zero divisor runs the raw dividend unsigned so the remainder
          // comes out as the untouched MDIn1 and the quotient as all ones.
          acc_lo_d  = zero_div ? md.MDIn1 : mag1;
          neg_d     = zero_div ? 1'b0 : (n1 ^ n2);
          rem_neg_d = zero_div ? 1'b0 : n1;
        end
      end
      S_CALC: begin
        if (!md.Flush) begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      S_FIX: begin
        if (!md.Flush) begin
          done_d = 1'b1;
          dbz_d  = dz_q;
          if (!is_div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else begin
            hi_d = rem;
            lo_d = dz_q ? WIDTH'(DIVZERO_LO) : quo;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and architectural register flops
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign md.Busy      = busy;
  assign md.Done      = done_q;
  assign md.DivByZero = dbz_q;
  assign md.Hi        = hi_q;
  assign md.Lo        = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module  : tb_mul_div_unit
// Purpose : Directed self-checking bench for mul_div_unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  logic Clk;
  logic Reset;
  int   total;
  int   bad;

  mul_div_unit_if #(.WIDTH(32)) md ();

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .md    (md)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Launch one operation; lat returns the cycle index (Start edge = 0) in
  // which Done was seen, or 60 if it never came.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    md.Op    = op;
    md.MDIn1 = a;
    md.MDIn2 = b;
    md.Start = 1'b1;
    tick();
    md.Start = 1'b0;
    lat = 1;
    while (md.Done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    total++;
    if ({md.Hi, md.Lo} !== 64'h0) begin
      bad++; $display("FAIL reset_hilo: got %h_%h want 0_0", md.Hi, md.Lo);
    end
    total++;
    if ({md.Busy, md.Done, md.DivByZero} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got busy/done/dbz=%b want 000",
                      {md.Busy, md.Done, md.DivByZero});
    end
    #2 Reset = 1'b0;
    tick();
  endtask

  task automatic test_mult_timing();
    int busy_err = 0;
    md.Op = 2'b00; md.MDIn1 = 32'd7; md.MDIn2 = 32'hFFFF_FFFD; md.Start = 1'b1;
    tick();
    md.Start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (md.Busy !== 1'b1 || md.Done !== 1'b0) busy_err++;
      tick();
    end
    total++;
    if (busy_err != 0) begin
      bad++; $display("FAIL mult_busy_window: got %0d bad cycles want 0", busy_err);
    end
    total++;
    if ({md.Busy, md.Done} !== 2'b01) begin
      bad++; $display("FAIL mult_done_cycle: got busy/done=%b want 01", {md.Busy, md.Done});
    end
    total++;
    if ({md.Hi, md.Lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      bad++; $display("FAIL mult_7x-3: got %h_%h want ffffffff_ffffffeb", md.Hi, md.Lo);
    end
    tick();
    total++;
    if (md.Done !== 1'b0) begin
      bad++; $display("FAIL mult_done_pulse: got %b want 0", md.Done);
    end
  endtask

  task automatic test_multu_div();
    int lat;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    total++;
    if (lat != 34 || {md.Hi, md.Lo} !== 64'hFFFF_FFFE_0000_0001) begin
      bad++; $display("FAIL multu_max: got lat=%0d %h_%h want 34 fffffffe_00000001", lat, md.Hi, md.Lo);
    end
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
    total++;
    if (lat != 34 || {md.Hi, md.Lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      bad++; $display("FAIL div_-7/2: got lat=%0d %h_%h want 34 ffffffff_fffffffd", lat, md.Hi, md.Lo);
    end
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat);
    total++;
    if ({md.Hi, md.Lo} !== 64'h0000_0001_FFFF_FFFD) begin
      bad++; $display("FAIL div_7/-2: got %h_%h want 00000001_fffffffd", md.Hi, md.Lo);
    end
    run_op(2'b11, 32'd100, 32'd7, lat);
    total++;
    if ({md.Hi, md.Lo} !== 64'h0000_0002_0000_000E || md.DivByZero !== 1'b0) begin
      bad++; $display("FAIL divu_100/7: got %h_%h dbz=%b want 00000002_0000000e 0", md.Hi, md.Lo, md.DivByZero);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(2'b11, 32'd100, 32'd0, lat);
    total++;
    if (lat != 34 || {md.Hi, md.Lo} !== 64'h0000_0064_FFFF_FFFF || md.DivByZero !== 1'b1) begin
      bad++; $display("FAIL divu_by_zero: got lat=%0d %h_%h dbz=%b want 34 00000064_ffffffff 1",
                      lat, md.Hi, md.Lo, md.DivByZero);
    end
    tick();
    total++;
    if (md.DivByZero !== 1'b1) begin
      bad++; $display("FAIL dbz_hold: got %b want 1", md.DivByZero);
    end
    md.Op = 2'b11; md.MDIn1 = 32'd9; md.MDIn2 = 32'd4; md.Start = 1'b1;
    tick();
    md.Start = 1'b0;
    total++;
    if (md.DivByZero !== 1'b0) begin
      bad++; $display("FAIL dbz_clear_on_start: got %b want 0", md.DivByZero);
    end
    lat = 1;
    while (md.Done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    total++;
    if (lat != 34 || {md.Hi, md.Lo} !== 64'h0000_0001_0000_0002 || md.DivByZero !== 1'b0) begin
      bad++; $display("FAIL divu_9/4: got lat=%0d %h_%h dbz=%b want 34 00000001_00000002 0",
                      lat, md.Hi, md.Lo, md.DivByZero);
    end
  endtask

  task automatic test_flush();
    int lat;
    int done_seen = 0;
    tick();
    md.Op = 2'b00; md.MDIn1 = 32'd5; md.MDIn2 = 32'd6; md.Start = 1'b1;
    tick();
    md.Start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    md.MDIn1 = 32'd100; md.MDIn2 = 32'd100; md.Start = 1'b1;
    tick();
    md.Start = 1'b0;
    tick();
    md.Flush = 1'b1;
    tick();
    md.Flush = 1'b0;
    total++;
    if (md.Busy !== 1'b0) begin
      bad++; $display("FAIL flush_busy_drop: got %b want 0", md.Busy);
    end
    for (int c = 0; c < 40; c++) begin
      if (md.Done === 1'b1) done_seen++;
      tick();
    end
    total++;
    if (done_seen != 0 || {md.Hi, md.Lo} !== 64'h0000_0001_0000_0002) begin
      bad++; $display("FAIL flush_no_done: got done=%0d %h_%h want 0 00000001_00000002",
                      done_seen, md.Hi, md.Lo);
    end
    md.Flush = 1'b1; md.Start = 1'b1;
    tick();
    md.Flush = 1'b0; md.Start = 1'b0;
    total++;
    if (md.Busy !== 1'b0) begin
      bad++; $display("FAIL flush_beats_start: got busy=%b want 0", md.Busy);
    end
    run_op(2'b00, 32'd5, 32'd6, lat);
    total++;
    if (lat != 34 || {md.Hi, md.Lo} !== 64'h0000_0000_0000_001E) begin
      bad++; $display("FAIL mult_after_flush: got lat=%0d %h_%h want 34 00000000_0000001e", lat, md.Hi, md.Lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    int lat;
    md.HiWrite = 1'b1; md.WrData = 32'hA5A5_A5A5;
    tick();
    md.HiWrite = 1'b0;
    total++;
    if (md.Hi !== 32'hA5A5_A5A5) begin
      bad++; $display("FAIL mthi: got %h want a5a5a5a5", md.Hi);
    end
    md.LoWrite = 1'b1; md.WrData = 32'h5A5A_5A5A;
    tick();
    md.LoWrite = 1'b0;
    total++;
    if ({md.Hi, md.Lo} !== 64'hA5A5_A5A5_5A5A_5A5A) begin
      bad++; $display("FAIL mtlo: got %h_%h want a5a5a5a5_5a5a5a5a", md.Hi, md.Lo);
    end
    md.Op = 2'b01; md.MDIn1 = 32'd3; md.MDIn2 = 32'd4; md.Start = 1'b1;
    tick();
    md.Start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    md.HiWrite = 1'b1; md.LoWrite = 1'b1; md.WrData = 32'hDEAD_BEEF;
    tick();
    md.HiWrite = 1'b0; md.LoWrite = 1'b0;
    total++;
    if ({md.Hi, md.Lo} !== 64'hA5A5_A5A5_5A5A_5A5A) begin
      bad++; $display("FAIL write_while_busy: got %h_%h want a5a5a5a5_5a5a5a5a", md.Hi, md.Lo);
    end
    lat = 6;
    while (md.Done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    total++;
    if (lat != 34 || {md.Hi, md.Lo} !== 64'h0000_0000_0000_000C) begin
      bad++; $display("FAIL multu_after_writes: got lat=%0d %h_%h want 34 00000000_0000000c", lat, md.Hi, md.Lo);
    end
    md.HiWrite = 1'b1; md.LoWrite = 1'b1; md.WrData = 32'h1234_5678;
    tick();
    md.HiWrite = 1'b0; md.LoWrite = 1'b0;
    total++;
    if ({md.Hi, md.Lo} !== 64'h1234_5678_1234_5678) begin
      bad++; $display("FAIL mthi_mtlo_both: got %h_%h want 12345678_12345678", md.Hi, md.Lo);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    md.Op = 2'b10; md.MDIn1 = 32'd100; md.MDIn2 = 32'd3; md.Start = 1'b1;
    tick();
    md.Start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    #2 Reset = 1'b1;
    #1;
    total++;
    if ({md.Hi, md.Lo} !== 64'h0 || {md.Busy, md.Done} !== 2'b00) begin
      bad++; $display("FAIL async_reset: got %h_%h busy/done=%b want 0_0 00",
                      md.Hi, md.Lo, {md.Busy, md.Done});
    end
    #2 Reset = 1'b0;
    tick();
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    total++;
    if (lat != 34 || {md.Hi, md.Lo} !== 64'h0000_0000_8000_0000 || md.DivByZero !== 1'b0) begin
      bad++; $display("FAIL div_overflow: got lat=%0d %h_%h dbz=%b want 34 00000000_80000000 0",
                      lat, md.Hi, md.Lo, md.DivByZero);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    Reset      = 1'b0;
    md.Start   = 1'b0;
    md.Op      = 2'b00;
    md.MDIn1   = '0;
    md.MDIn2   = '0;
    md.Flush   = 1'b0;
    md.HiWrite = 1'b0;
    md.LoWrite = 1'b0;
    md.WrData  = '0;
    #2;
    test_reset();
    test_mult_timing();
    test_multu_div();
    test_div_zero();
    test_flush();
    test_mthi_mtlo();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
